plab2_proc_muldiv_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit; successor to the single-cycle ALU for the
//  5-stage processor. Sits beside the ALU in X and serves MUL/DIV/DIVU/REM/REMU through
//  val/rdy handshakes. Carries a security domain per request and labels the response with it.

---
 rtl/plab2_proc_muldiv_iter_pkg.sv | 16 +
 rtl/plab2_proc_muldiv_iter_dpath.sv | 100 ++++++++++
 rtl/plab2_proc_muldiv_iter.sv | 103 ++++++++++
 tb/tb_plab2_proc_muldiv_iter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/plab2_proc_muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: function codes and FSM states.
package plab2_proc_muldiv_iter_pkg;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/plab2_proc_muldiv_iter_dpath.sv
// Datapath: shift-add multiply, restoring divide on magnitudes, sign fix into a result register.
module plab2_proc_muldiv_iter_dpath
    import plab2_proc_muldiv_iter_pkg::*;
#(
    parameter int P_NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic               clear,
    input  logic [2:0]         fn,
    input  logic [P_NBITS-1:0] a,
    input  logic [P_NBITS-1:0] b,
    output logic [P_NBITS-1:0] result
);

    logic [2:0]         fn_q;
    logic [P_NBITS-1:0] reg_a;     // MUL: multiplicand (shifts left); DIV: dividend -> quotient
    logic [P_NBITS-1:0] reg_b;     // MUL: multiplier (shifts right); DIV: divisor magnitude
    logic [P_NBITS-1:0] acc;       // MUL: product; DIV: partial remainder
    logic [P_NBITS-1:0] a_orig;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;
    logic [P_NBITS-1:0] result_q;

    logic               is_signed;
    logic [P_NBITS-1:0] a_mag;
    logic [P_NBITS-1:0] b_mag;
    logic [P_NBITS:0]   rem_shift;
    logic [P_NBITS:0]   diff;
    logic [P_NBITS-1:0] res;

    always_comb begin
        is_signed = (fn == FN_DIV) || (fn == FN_REM);
        a_mag     = (is_signed && a[P_NBITS-1]) ? -a : a;
        b_mag     = (is_signed && b[P_NBITS-1]) ? -b : b;
        rem_shift = {acc, reg_a[P_NBITS-1]};
        diff      = rem_shift - {1'b0, reg_b};
    end

    // MIN / -1 falls out naturally: |MIN| = MIN, quotient MIN, no negation, remainder 0.
    always_comb begin
        res = '0;
        case (fn_q)
            FN_MUL:          res = acc;
            FN_DIV, FN_DIVU: res = b_zero ? '1 : (neg_q ? -reg_a : reg_a);
            FN_REM, FN_REMU: res = b_zero ? a_orig : (neg_r ? -acc : acc);
            default:         res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fn_q     <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            acc      <= '0;
            a_orig   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            result_q <= '0;
        end else begin
            if (load) begin
                fn_q   <= fn;
                reg_a  <= (fn == FN_MUL) ? a : a_mag;
                reg_b  <= (fn == FN_MUL) ? b : b_mag;
                acc    <= '0;
                a_orig <= a;
                neg_q  <= is_signed && (a[P_NBITS-1] ^ b[P_NBITS-1]);
                neg_r  <= is_signed && a[P_NBITS-1];
                b_zero <= (b == '0);
            end else if (step) begin
                if (fn_q == FN_MUL) begin
                    acc   <= acc + (reg_b[0] ? reg_a : '0);
                    reg_a <= reg_a << 1;
                    reg_b <= reg_b >> 1;
                end else if (!diff[P_NBITS]) begin
                    acc   <= diff[P_NBITS-1:0];
                    reg_a <= {reg_a[P_NBITS-2:0], 1'b1};
                end else begin
                    acc   <= rem_shift[P_NBITS-1:0];
                    reg_a <= {reg_a[P_NBITS-2:0], 1'b0};
                end
            end

            if (clear) begin
                result_q <= '0;
            end else if (finish) begin
                result_q <= res;
            end
        end
    end

    assign result = result_q;

endmodule

// File: rtl/plab2_proc_muldiv_iter.sv
// Iterative MUL/DIV/DIVU/REM/REMU unit with val/rdy handshakes and per-request domain label.
//  state   | meaning
//  IDLE    | ready for a request
//  CALC    | P_NBITS iteration cycles, then one sign-fix cycle into the result register
//  DONE    | result valid, held until consumed or squashed
module plab2_proc_muldiv_iter
    import plab2_proc_muldiv_iter_pkg::*;
#(
    parameter int P_NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_domain,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2:0]         req_fn,
    input  logic [P_NBITS-1:0] req_a,
    input  logic [P_NBITS-1:0] req_b,
    input  logic               squash,
    output logic               resp_domain,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [P_NBITS-1:0] resp_data
);

    localparam int CW = $clog2(P_NBITS) + 1;

    state_e        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          domain_q;
    logic          accept;
    logic          step;
    logic          finish;
    logic          clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            domain_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                domain_q <= req_domain;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        clear     = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = req_val;
                if (req_val) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (squash) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CW'(P_NBITS)) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    step    = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                // squash wins over a same-cycle handshake; both drop the result.
                if (squash || resp_rdy) begin
                    clear     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    plab2_proc_muldiv_iter_dpath #(.P_NBITS(P_NBITS)) u_dpath (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (step),
        .finish (finish),
        .clear  (clear),
        .fn     (req_fn),
        .a      (req_a),
        .b      (req_b),
        .result (resp_data)
    );

    assign req_rdy     = (state == ST_IDLE);
    assign resp_val    = (state == ST_DONE);
    assign resp_domain = domain_q;

endmodule

// File: tb/tb_plab2_proc_muldiv_iter.sv
// Directed + random bench for plab2_proc_muldiv_iter with a result/domain scoreboard.
module tb_plab2_proc_muldiv_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_domain;
    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_fn;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        squash;
    logic        resp_domain;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_data;

    typedef struct {
        logic [31:0] data;
        logic        dom;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    plab2_proc_muldiv_iter #(.P_NBITS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_domain  (req_domain),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_fn      (req_fn),
        .req_a       (req_a),
        .req_b       (req_b),
        .squash      (squash),
        .resp_domain (resp_domain),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_data   (resp_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (fn)
            3'd0: model = a * b;
            3'd1: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                                   : 32'($signed(a) / $signed(b));
            3'd2: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd3: model = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            3'd4: model = (b == 0) ? a : a % b;
            default: model = 32'h0;
        endcase
    endfunction

    // One full transaction; the offered domain is flipped during CALC to show it is not re-sampled.
    task automatic do_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic dom, input logic [31:0] exp,
                         input int stall);
        exp_t e;
        exp_t got;
        int   n;
        logic seen;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(req_rdy), 32'd1);
        req_val    = 1'b1;
        req_fn     = fn;
        req_a      = a;
        req_b      = b;
        req_domain = dom;
        resp_rdy   = (stall == 0);
        @(posedge clk);
        e.data = exp;
        e.dom  = dom;
        sb.push_back(e);
        #1;
        req_val    = 1'b0;
        req_domain = ~dom;
        n    = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = resp_val;
        end
        got = sb.pop_front();
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_lat"}, 32'(n), 32'd33);
            chk({tag, "_data"}, resp_data, got.data);
            chk({tag, "_dom"}, 32'(resp_domain), 32'(got.dom));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk({tag, "_stall_val"}, 32'(resp_val), 32'd1);
                chk({tag, "_stall_data"}, resp_data, got.data);
                chk({tag, "_stall_dom"}, 32'(resp_domain), 32'(got.dom));
                chk({tag, "_stall_rdy"}, 32'(req_rdy), 32'd0);
            end
            @(negedge clk);
            resp_rdy = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_drop_val"}, 32'(resp_val), 32'd0);
            chk({tag, "_drop_data"}, resp_data, 32'd0);
        end
    endtask

    initial begin
        int highs;
        reset      = 1'b0;
        req_domain = 1'b0;
        req_val    = 1'b0;
        req_fn     = 3'd0;
        req_a      = '0;
        req_b      = '0;
        squash     = 1'b0;
        resp_rdy   = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_val", 32'(resp_val), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_dom", 32'(resp_domain), 32'd0);
        reset = 1'b1;

        // Reset asserted in the middle of CALC.
        @(negedge clk);
        req_val = 1'b1; req_fn = 3'd0; req_a = 32'd9; req_b = 32'd9; req_domain = 1'b1;
        @(posedge clk);
        #1 req_val = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("calc_rdy", 32'(req_rdy), 32'd0);
        reset = 1'b0;
        #1;
        chk("midrst_val", 32'(resp_val), 32'd0);
        chk("midrst_data", resp_data, 32'd0);
        chk("midrst_dom", 32'(resp_domain), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_rdy", 32'(req_rdy), 32'd1);
        chk("postrst_val", 32'(resp_val), 32'd0);

        do_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 0);
        do_op("div_neg",   3'd1, 32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD, 0);
        do_op("rem_neg",   3'd3, 32'hFFFF_FFF9,  32'd2,         1'b0, 32'hFFFF_FFFF, 0);
        do_op("divu",      3'd2, 32'd100,        32'd7,         1'b1, 32'd14,        0);
        do_op("remu",      3'd4, 32'd100,        32'd7,         1'b0, 32'd2,         0);
        do_op("divu_z",    3'd2, 32'd5,          32'd0,         1'b0, 32'hFFFF_FFFF, 0);
        do_op("remu_z",    3'd4, 32'd5,          32'd0,         1'b1, 32'd5,         0);
        do_op("rem_z",     3'd3, 32'hFFFF_FFF9,  32'd0,         1'b0, 32'hFFFF_FFF9, 0);
        do_op("div_ovf",   3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 0);
        do_op("rem_ovf",   3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'd0,         0);
        do_op("div_pn",    3'd1, 32'd20,         32'hFFFF_FFFA, 1'b0, 32'hFFFF_FFFD, 0);
        do_op("rem_pn",    3'd3, 32'd20,         32'hFFFF_FFFA, 1'b0, 32'd2,         0);
        do_op("illegal",   3'd6, 32'd123,        32'd45,        1'b1, 32'd0,         0);
        do_op("stall_dom", 3'd0, 32'h0001_0003,  32'h0000_0100, 1'b1, 32'h0100_0300, 5);

        // Squash at CALC count 10.
        @(negedge clk);
        req_val = 1'b1; req_fn = 3'd0; req_a = 32'd5; req_b = 32'd6; req_domain = 1'b1;
        @(posedge clk);
        #1 req_val = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        squash = 1'b1;
        @(posedge clk);
        #1;
        squash = 1'b0;
        chk("squash_rdy", 32'(req_rdy), 32'd1);
        chk("squash_val", 32'(resp_val), 32'd0);
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_val) highs++;
        end
        chk("squash_noresp", 32'(highs), 32'd0);
        do_op("mul_after", 3'd0, 32'd3, 32'd4, 1'b0, 32'd12, 0);

        // Squash in DONE overrides a same-cycle handshake; next op unaffected.
        @(negedge clk);
        req_val = 1'b1; req_fn = 3'd2; req_a = 32'd50; req_b = 32'd5; req_domain = 1'b0;
        @(posedge clk);
        #1 req_val = 1'b0;
        repeat (33) @(posedge clk);
        @(negedge clk);
        chk("done_sq_val", 32'(resp_val), 32'd1);
        chk("done_sq_data", resp_data, 32'd10);
        squash = 1'b1;
        @(posedge clk);
        #1 squash = 1'b0;
        chk("done_sq_drop", 32'(resp_val), 32'd0);
        chk("done_sq_zero", resp_data, 32'd0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  f;
            logic [31:0] ra;
            logic [31:0] rb;
            f  = 3'($urandom_range(0, 4));
            ra = $urandom;
            rb = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
            if (i[0]) rb = rb >> 20;
            do_op("rand", f, ra, rb, 1'(i), model(f, ra, rb), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
